// File: rtl/mux_pkg.sv
// Shared types and select-code helpers for the channel selector.
package mux_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    BLANK = 1'b1
  } mux_state_t;

  // The first code past the channel range selects the DC full-scale source.
  function automatic int unsigned sel_dc_code(input int unsigned ch_num);
    return ch_num;
  endfunction

  function automatic logic sel_is_chan(input int unsigned sel, input int unsigned ch_num);
    return (sel < ch_num);
  endfunction

endpackage

// File: rtl/ch_width_conv.sv
// Combinational sample width converter: MSB truncation, or round-half-up with
// saturation when MUX_ROUND_EN is defined.
module ch_width_conv #(
  parameter int unsigned IW = 12,
  parameter int unsigned OW = 12
) (
  input  logic [IW-1:0] src,
  output logic [OW-1:0] dst
);

  if (IW == OW) begin : g_pass
    assign dst = src;
  end else begin : g_conv
    localparam int unsigned SH = IW - OW;
`ifdef MUX_ROUND_EN
    localparam logic [IW:0] HALF = (IW + 1)'(1) << (SH - 1);
    logic [IW:0] sum;
    logic [OW:0] quo;

    assign sum = {1'b0, src} + HALF;
    assign quo = sum[IW:SH];
    // A carry into bit OW means the rounded value no longer fits: clamp to full scale.
    assign dst = quo[OW] ? '1 : quo[OW-1:0];
`else
    logic unused_lsb;

    assign dst        = src[IW-1 -: OW];
    assign unused_lsb = ^src[SH-1:0];
`endif
  end

endmodule

// File: rtl/ch_sel_mux.sv
// N-channel sample selector with registered output and muted blanking window
// on source changes. Optional build macro: MUX_ROUND_EN (rounding width conversion).
module ch_sel_mux
  import mux_pkg::*;
#(
  parameter int unsigned CH_NUM       = 4,
  parameter int unsigned INPUT_WIDTH  = 12,
  parameter int unsigned OUTPUT_WIDTH = 12,
  parameter int unsigned BLANK_LEN    = 4,
  parameter int unsigned SEL_WIDTH    = $clog2(CH_NUM + 2)
) (
  input  logic                          CLK,
  input  logic                          RST_n,
  input  logic [SEL_WIDTH-1:0]          Sel,
  input  logic [CH_NUM*INPUT_WIDTH-1:0] CH_IN,
  input  logic                          in_valid,
  output logic [OUTPUT_WIDTH-1:0]       CH_out,
  output logic                          out_valid,
  output logic                          switching
);

  localparam int unsigned CNT_W = (BLANK_LEN > 0) ? $clog2(BLANK_LEN + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BLANK_LEN);

  mux_state_t              state, state_nxt;
  logic [SEL_WIDTH-1:0]    sel_act, sel_nxt;
  logic [CNT_W-1:0]        blank_cnt, cnt_nxt;
  logic [SEL_WIDTH-1:0]    code_use;
  logic                    mute;
  logic                    sel_change;
  logic [INPUT_WIDTH-1:0]  src;
  logic [OUTPUT_WIDTH-1:0] conv;

  assign sel_change = (Sel != sel_act);

  // A change seen in RUN already steers the coincident sample: muted when a
  // window follows, otherwise taken straight from the new source.
  always_comb begin
    state_nxt = state;
    sel_nxt   = sel_act;
    cnt_nxt   = blank_cnt;
    code_use  = sel_act;
    mute      = 1'b0;
    case (state)
      RUN: begin
        if (sel_change) begin
          sel_nxt  = Sel;
          code_use = Sel;
          if (BLANK_LEN > 0) begin
            state_nxt = BLANK;
            cnt_nxt   = CNT_LOAD;
            mute      = 1'b1;
          end
        end
      end
      BLANK: begin
        mute = 1'b1;
        if (sel_change) begin
          sel_nxt = Sel;
          cnt_nxt = CNT_LOAD;
        end else if (in_valid) begin
          cnt_nxt = (blank_cnt != '0) ? blank_cnt - CNT_W'(1) : '0;
          if (blank_cnt <= CNT_W'(1)) state_nxt = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    src = '0;
    if (sel_is_chan(32'(code_use), CH_NUM)) begin
      for (int unsigned k = 0; k < CH_NUM; k++) begin
        if (code_use == SEL_WIDTH'(k)) src = CH_IN[k*INPUT_WIDTH +: INPUT_WIDTH];
      end
    end else if (code_use == SEL_WIDTH'(sel_dc_code(CH_NUM))) begin
      src = '1;
    end
  end

  ch_width_conv #(
    .IW (INPUT_WIDTH),
    .OW (OUTPUT_WIDTH)
  ) u_conv (
    .src (src),
    .dst (conv)
  );

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state     <= RUN;
      sel_act   <= '0;
      blank_cnt <= '0;
      CH_out    <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      sel_act   <= sel_nxt;
      blank_cnt <= cnt_nxt;
      out_valid <= in_valid;
      if (in_valid) CH_out <= mute ? '0 : conv;
    end
  end

  assign switching = (state == BLANK);

endmodule

// File: tb/tb_ch_sel_mux.sv
// Directed bench for ch_sel_mux: a 12-bit/BLANK_LEN=4 instance plus an
// 8-bit/no-blanking instance for width conversion. Honors MUX_ROUND_EN.
module tb_ch_sel_mux;

  logic        CLK = 1'b0;
  logic        RST_n;
  logic [2:0]  Sel;
  logic [47:0] CH_IN;
  logic        in_valid;
  logic [11:0] CH_out;
  logic        out_valid;
  logic        switching;
  logic [7:0]  CH_out8;
  logic        out_valid8;
  logic        switching8;

  int unsigned n_cmp = 0;
  int unsigned n_mis = 0;

  always #5 CLK = ~CLK;

  ch_sel_mux #(
    .CH_NUM       (4),
    .INPUT_WIDTH  (12),
    .OUTPUT_WIDTH (12),
    .BLANK_LEN    (4)
  ) dut (
    .CLK       (CLK),
    .RST_n     (RST_n),
    .Sel       (Sel),
    .CH_IN     (CH_IN),
    .in_valid  (in_valid),
    .CH_out    (CH_out),
    .out_valid (out_valid),
    .switching (switching)
  );

  ch_sel_mux #(
    .CH_NUM       (4),
    .INPUT_WIDTH  (12),
    .OUTPUT_WIDTH (8),
    .BLANK_LEN    (0)
  ) dut8 (
    .CLK       (CLK),
    .RST_n     (RST_n),
    .Sel       (Sel),
    .CH_IN     (CH_IN),
    .in_valid  (in_valid),
    .CH_out    (CH_out8),
    .out_valid (out_valid8),
    .switching (switching8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic set_ch(input int unsigned k, input logic [11:0] v);
    CH_IN[k*12 +: 12] = v;
  endtask

  // Run out a pending 4-sample window without checking it.
  task automatic drain();
    for (int i = 0; i < 4; i++) pulse();
  endtask

  logic [7:0] e_8f, e_88;

  initial begin
`ifdef MUX_ROUND_EN
    e_8f = 8'h09;
    e_88 = 8'h09;
`else
    e_8f = 8'h08;
    e_88 = 8'h08;
`endif
    RST_n    = 1'b0;
    Sel      = 3'd0;
    in_valid = 1'b0;
    CH_IN    = '0;
    set_ch(0, 12'h123);
    set_ch(1, 12'h456);
    set_ch(2, 12'hA5C);
    set_ch(3, 12'h789);

    // 1: reset holds outputs low even with strobes arriving
    for (int i = 0; i < 3; i++) begin
      in_valid = ~in_valid;
      tick();
    end
    in_valid = 1'b0;
    check("rst_out", 32'(CH_out), 32'h0);
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_switching", 32'(switching), 32'h0);
    RST_n = 1'b1;
    tick();
    pulse();
    check("first_ch0", 32'(CH_out), 32'h123);
    check("first_valid", 32'(out_valid), 32'h1);
    tick();
    check("idle_valid", 32'(out_valid), 32'h0);
    check("idle_hold", 32'(CH_out), 32'h123);

    // 2: select ch2 and let the window settle
    Sel = 3'd2;
    tick();
    check("sel2_switching", 32'(switching), 32'h1);
    drain();
    check("sel2_settled", 32'(switching), 32'h0);
    tick();
    check("sel2_novalid", 32'(out_valid), 32'h0);
    pulse();
    check("sel2_data", 32'(CH_out), 32'hA5C);
    check("sel2_valid", 32'(out_valid), 32'h1);

    // 3: switch 0 -> 1 with six samples
    Sel = 3'd0;
    tick();
    drain();
    pulse();
    check("run_ch0", 32'(CH_out), 32'h123);
    Sel = 3'd1;
    tick();
    check("sw_switching", 32'(switching), 32'h1);
    for (int i = 0; i < 6; i++) begin
      pulse();
      check($sformatf("sw_out%0d", i), 32'(CH_out), (i < 4) ? 32'h0 : 32'h456);
      check($sformatf("sw_valid%0d", i), 32'(out_valid), 32'h1);
      check($sformatf("sw_swi%0d", i), 32'(switching), (i < 3) ? 32'h1 : 32'h0);
    end

    // 4: DC and zero codes, then a change mid-window restarts it
    Sel = 3'd4;
    tick();
    drain();
    pulse();
    check("dc_code", 32'(CH_out), 32'hFFF);
    check("dc_code8", 32'(CH_out8), 32'hFF);
    Sel = 3'd5;
    tick();
    drain();
    pulse();
    check("zero_code", 32'(CH_out), 32'h0);
    check("zero_code8", 32'(CH_out8), 32'h0);
    Sel = 3'd3;
    tick();
    pulse();
    pulse();
    Sel = 3'd1;
    tick();
    check("restart_switching", 32'(switching), 32'h1);
    for (int i = 0; i < 4; i++) begin
      pulse();
      check($sformatf("restart_mute%0d", i), 32'(CH_out), 32'h0);
      check($sformatf("restart_swi%0d", i), 32'(switching), (i < 3) ? 32'h1 : 32'h0);
    end
    pulse();
    check("restart_data", 32'(CH_out), 32'h456);

    // 5: reset in the middle of a window
    Sel = 3'd2;
    tick();
    pulse();
    check("mid_mute", 32'(CH_out), 32'h0);
    check("mid_switching", 32'(switching), 32'h1);
    Sel   = 3'd0;
    RST_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'h0);
    check("mid_rst_switching", 32'(switching), 32'h0);
    check("mid_rst_out", 32'(CH_out), 32'h0);
    tick();
    RST_n = 1'b1;
    tick();
    pulse();
    check("post_rst_data", 32'(CH_out), 32'h123);
    check("post_rst_switching", 32'(switching), 32'h0);

    // 6: width conversion on the 8-bit instance (ch0 routed)
    set_ch(0, 12'h077); pulse(); check("wc_077", 32'(CH_out8), 32'h07);
    set_ch(0, 12'h080); pulse(); check("wc_080", 32'(CH_out8), 32'h08);
    set_ch(0, 12'hFF8); pulse(); check("wc_ff8", 32'(CH_out8), 32'hFF);
    set_ch(0, 12'h08F); pulse(); check("wc_08f", 32'(CH_out8), 32'(e_8f));
    set_ch(0, 12'h088); pulse(); check("wc_088", 32'(CH_out8), 32'(e_88));
    check("wc_full12", 32'(CH_out), 32'h088);

    // Zero-length window: switch and sample in the same cycle uses the new source
    Sel      = 3'd1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("nb_immediate", 32'(CH_out8), 32'h45);
    check("nb_switching", 32'(switching8), 32'h0);
    check("coinc_mute", 32'(CH_out), 32'h0);
    check("coinc_switching", 32'(switching), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
